// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings, requester indices and helpers for ram_port_arbiter
package mem_arb_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam int CNT_W = 3;
    typedef logic [1:0] req_idx_t;
    function automatic req_idx_t next_req(input req_idx_t i);
        return (i == REQ_C) ? REQ_A : i + 2'd1;
    endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester A/B/C handshake bus plus RAM-side bus.
//   i_X_REQ/i_X_WR/i_X_ADDR/i_X_DATA_WR : requester X transaction request
//   o_X_GNT/o_X_RVALID/o_X_DATA_RD      : grant pulse, read-valid pulse, held read data
//   o_RAM_*/i_RAM_DATA_RD               : RAM strobes, address, write data, read data
//   o_BUSY                              : arbiter not idle
//   slave = arbiter side, master = requesters/RAM side
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_A_REQ, i_B_REQ, i_C_REQ;
    logic              i_A_WR, i_B_WR, i_C_WR;
    logic [ADDR_W-1:0] i_A_ADDR, i_B_ADDR, i_C_ADDR;
    logic [DATA_W-1:0] i_A_DATA_WR, i_B_DATA_WR, i_C_DATA_WR;
    logic              o_A_GNT, o_B_GNT, o_C_GNT;
    logic              o_A_RVALID, o_B_RVALID, o_C_RVALID;
    logic [DATA_W-1:0] o_A_DATA_RD, o_B_DATA_RD, o_C_DATA_RD;
    logic              o_RAM_CE, o_RAM_RD, o_RAM_WR;
    logic [ADDR_W-1:0] o_RAM_ADDR;
    logic [DATA_W-1:0] o_RAM_DATA_WR;
    logic [DATA_W-1:0] i_RAM_DATA_RD;
    logic              o_BUSY;
    modport slave (
        input  i_A_REQ, i_B_REQ, i_C_REQ, i_A_WR, i_B_WR, i_C_WR,
        input  i_A_ADDR, i_B_ADDR, i_C_ADDR, i_A_DATA_WR, i_B_DATA_WR, i_C_DATA_WR,
        output o_A_GNT, o_B_GNT, o_C_GNT, o_A_RVALID, o_B_RVALID, o_C_RVALID,
        output o_A_DATA_RD, o_B_DATA_RD, o_C_DATA_RD,
        output o_RAM_CE, o_RAM_RD, o_RAM_WR, o_RAM_ADDR, o_RAM_DATA_WR, o_BUSY,
        input  i_RAM_DATA_RD
    );
    modport master (
        output i_A_REQ, i_B_REQ, i_C_REQ, i_A_WR, i_B_WR, i_C_WR,
        output i_A_ADDR, i_B_ADDR, i_C_ADDR, i_A_DATA_WR, i_B_DATA_WR, i_C_DATA_WR,
        input  o_A_GNT, o_B_GNT, o_C_GNT, o_A_RVALID, o_B_RVALID, o_C_RVALID,
        input  o_A_DATA_RD, o_B_DATA_RD, o_C_DATA_RD,
        input  o_RAM_CE, o_RAM_RD, o_RAM_WR, o_RAM_ADDR, o_RAM_DATA_WR, o_BUSY,
        output i_RAM_DATA_RD
    );
endinterface

// File: rtl/rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker.
//   req[2:0] : request vector (bit 0 = A)
//   ptr[1:0] : highest-priority requester index
//   valid    : any request present
//   idx[1:0] : first requester at or after ptr in cyclic order A,B,C
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);
    assign valid = |req;
    assign idx = (ptr == REQ_B) ? (req[1] ? REQ_B : req[2] ? REQ_C : REQ_A) :
                 (ptr == REQ_C) ? (req[2] ? REQ_C : req[0] ? REQ_A : REQ_B) :
                                  (req[0] ? REQ_A : req[1] ? REQ_B : REQ_C);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one single-port RAM among three requesters.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : requester handshakes and RAM port (ram_port_arbiter_if.slave)
module ram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    ram_port_arbiter_if.slave     bus
);
    logic [1:0]              state_q, state_d;
    logic [1:0]              ptr_q, ptr_d;
    logic [1:0]              sel_q, sel_d;
    logic                    wr_q, wr_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              rvalid_q, rvalid_d;
    logic [2:0][DATA_W-1:0]  rdata_q, rdata_d;
    logic [2:0]              req;
    logic                    pick_valid;
    logic [1:0]              pick_idx;
    logic                    issue;

    assign req = {bus.i_C_REQ, bus.i_B_REQ, bus.i_A_REQ};

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: if (pick_valid) begin
                sel_d   = pick_idx;
                wr_d    = (pick_idx == REQ_B) ? bus.i_B_WR : (pick_idx == REQ_C) ? bus.i_C_WR : bus.i_A_WR;
                addr_d  = (pick_idx == REQ_B) ? bus.i_B_ADDR : (pick_idx == REQ_C) ? bus.i_C_ADDR : bus.i_A_ADDR;
                wdata_d = (pick_idx == REQ_B) ? bus.i_B_DATA_WR : (pick_idx == REQ_C) ? bus.i_C_DATA_WR : bus.i_A_DATA_WR;
                state_d = ISSUE;
            end
            ISSUE: begin
                ptr_d   = next_req(sel_q);
                cnt_d   = CNT_W'(RD_LATENCY - 1);
                state_d = wr_q ? IDLE : WAIT;
            end
            WAIT: if (cnt_q == '0) begin
                for (int i = 0; i < 3; i++) begin
                    if (sel_q == 2'(i)) begin
                        rdata_d[i]  = bus.i_RAM_DATA_RD;
                        rvalid_d[i] = 1'b1;
                    end
                end
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= REQ_A;
            sel_q    <= REQ_A;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Latched fields only change on acceptance, so they double as the held RAM address/data.
    assign issue             = (state_q == ISSUE);
    assign bus.o_RAM_CE      = issue;
    assign bus.o_RAM_RD      = issue & ~wr_q;
    assign bus.o_RAM_WR      = issue & wr_q;
    assign bus.o_RAM_ADDR    = addr_q;
    assign bus.o_RAM_DATA_WR = wdata_q;
    assign bus.o_A_GNT       = issue & (sel_q == REQ_A);
    assign bus.o_B_GNT       = issue & (sel_q == REQ_B);
    assign bus.o_C_GNT       = issue & (sel_q == REQ_C);
    assign bus.o_A_RVALID    = rvalid_q[0];
    assign bus.o_B_RVALID    = rvalid_q[1];
    assign bus.o_C_RVALID    = rvalid_q[2];
    assign bus.o_A_DATA_RD   = rdata_q[0];
    assign bus.o_B_DATA_RD   = rdata_q[1];
    assign bus.o_C_DATA_RD   = rdata_q[2];
    assign bus.o_BUSY        = (state_q != IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter (latency-2 and latency-1 instances)
module tb_ram_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    typedef struct { logic [1:0] who; logic wr; logic [31:0] addr; logic [31:0] wdata; int cyc; } gexp_t;
    typedef struct { logic [1:0] who; logic [31:0] data; int cyc; } rexp_t;
    typedef struct { logic [1:0] who; logic wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp_rd; } vec_t;
    typedef struct { logic gnt; logic rv; logic rd; logic [31:0] addr; logic [31:0] data; } b2b_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   gnt_seen = 0;
    int   rv_seen = 0;
    logic auto_drop = 1'b1;
    logic [2:0] last_gnt = '0;
    logic [31:0] exp_rd [3];
    gexp_t gq [$];
    rexp_t rq [$];
    logic [7:0] p0, p1;
    logic [2:0] mg, mv;
    gexp_t ge;
    rexp_t re;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT0)) dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // RAM models: read data is valid only in the cycle exactly LAT cycles after the read strobe
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p0 <= '0;
            p1 <= '0;
        end else begin
            p0 <= {p0[6:0], bus0.o_RAM_RD};
            p1 <= {p1[6:0], bus1.o_RAM_RD};
        end
    end
    assign bus0.i_RAM_DATA_RD = p0[LAT0-1] ? ram_val(bus0.o_RAM_ADDR) : 32'hBAD0_BAD0;
    assign bus1.i_RAM_DATA_RD = p1[LAT1-1] ? ram_val(bus1.o_RAM_ADDR) : 32'hBAD0_BAD0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor for dut0
    always @(negedge clk) begin
        mg = {bus0.o_C_GNT, bus0.o_B_GNT, bus0.o_A_GNT};
        mv = {bus0.o_C_RVALID, bus0.o_B_RVALID, bus0.o_A_RVALID};
        last_gnt = rst ? 3'b000 : mg;
        if (!rst) begin
            chk("strobe_vs_gnt", {62'd0, bus0.o_RAM_CE, bus0.o_RAM_RD | bus0.o_RAM_WR}, {62'd0, |mg, |mg});
            if (mg != 0) begin
                gnt_seen++;
                if (gq.size() == 0) chk("unexpected_gnt", 64'(mg), 64'd0);
                else begin
                    ge = gq.pop_front();
                    chk("gnt_who", 64'(mg), 64'(3'b001 << ge.who));
                    chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                    chk("gnt_strobes", {62'd0, bus0.o_RAM_RD, bus0.o_RAM_WR}, {62'd0, ~ge.wr, ge.wr});
                    chk("gnt_addr_data", {bus0.o_RAM_ADDR, bus0.o_RAM_DATA_WR}, {ge.addr, ge.wdata});
                end
            end
            if (mv != 0) begin
                rv_seen++;
                if (rq.size() == 0) chk("unexpected_rvalid", 64'(mv), 64'd0);
                else begin
                    re = rq.pop_front();
                    chk("rvalid_who", 64'(mv), 64'(3'b001 << re.who));
                    chk("rvalid_cycle", 64'(cyc), 64'(re.cyc));
                    exp_rd[re.who] = re.data;
                end
            end
            chk("data_rd_ab", {bus0.o_A_DATA_RD, bus0.o_B_DATA_RD}, {exp_rd[0], exp_rd[1]});
            chk("data_rd_c", 64'(bus0.o_C_DATA_RD), 64'(exp_rd[2]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_drop) begin
            if (last_gnt[0]) bus0.i_A_REQ = 1'b0;
            if (last_gnt[1]) bus0.i_B_REQ = 1'b0;
            if (last_gnt[2]) bus0.i_C_REQ = 1'b0;
        end
    endtask

    task automatic set_req(input logic [1:0] w, input logic r, input logic wr, input logic [31:0] a, input logic [31:0] d);
        case (w)
            2'd0: begin bus0.i_A_REQ = r; bus0.i_A_WR = wr; bus0.i_A_ADDR = a; bus0.i_A_DATA_WR = d; end
            2'd1: begin bus0.i_B_REQ = r; bus0.i_B_WR = wr; bus0.i_B_ADDR = a; bus0.i_B_DATA_WR = d; end
            default: begin bus0.i_C_REQ = r; bus0.i_C_WR = wr; bus0.i_C_ADDR = a; bus0.i_C_DATA_WR = d; end
        endcase
    endtask

    task automatic expect_gnt(input logic [1:0] w, input logic wr, input logic [31:0] a, input logic [31:0] d, input int c);
        gexp_t g;
        g.who = w; g.wr = wr; g.addr = a; g.wdata = d; g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic expect_rv(input logic [1:0] w, input logic [31:0] d, input int c);
        rexp_t r;
        r.who = w; r.data = d; r.cyc = c;
        rq.push_back(r);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (gq.size() + rq.size()) != 0; i++) step();
        chk("drain", 64'(gq.size() + rq.size()), 64'd0);
        repeat (LAT0 + 2) step();
    endtask

    task automatic clear_inputs();
        for (int w = 0; w < 3; w++) set_req(2'(w), 1'b0, 1'b0, 32'd0, 32'd0);
        {bus1.i_A_REQ, bus1.i_B_REQ, bus1.i_C_REQ, bus1.i_A_WR, bus1.i_B_WR, bus1.i_C_WR} = '0;
        {bus1.i_A_ADDR, bus1.i_B_ADDR, bus1.i_C_ADDR} = '0;
        {bus1.i_A_DATA_WR, bus1.i_B_DATA_WR, bus1.i_C_DATA_WR} = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        gq.delete();
        rq.delete();
        for (int w = 0; w < 3; w++) exp_rd[w] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctrl"}, 64'({bus0.o_RAM_CE, bus0.o_RAM_RD, bus0.o_RAM_WR, bus0.o_A_GNT, bus0.o_B_GNT, bus0.o_C_GNT,
                                bus0.o_A_RVALID, bus0.o_B_RVALID, bus0.o_C_RVALID, bus0.o_BUSY}), 64'd0);
        chk({nm, "_addr_data"}, {bus0.o_RAM_ADDR, bus0.o_RAM_DATA_WR}, 64'd0);
        chk({nm, "_rd_ab"}, {bus0.o_A_DATA_RD, bus0.o_B_DATA_RD}, 64'd0);
        chk({nm, "_rd_c"}, 64'(bus0.o_C_DATA_RD), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int d;
        d = cyc;
        expect_gnt(v.who, v.wr, v.addr, v.wdata, d + 1);
        if (!v.wr) expect_rv(v.who, v.exp_rd, d + 2 + LAT0);
        set_req(v.who, 1'b1, v.wr, v.addr, v.wdata);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        b2b_t t6 [7];
        int d, base;
        vecs[0] = '{2'd0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
        vecs[1] = '{2'd1, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'h0};
        vecs[2] = '{2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'hA5A5_0040};
        vecs[3] = '{2'd1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_0008};
        vecs[4] = '{2'd2, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h0};
        vecs[5] = '{2'd0, 1'b1, 32'h0000_0104, 32'h0BAD_CAFE, 32'h0};
        t6[0] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h0};
        t6[1] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0};
        t6[2] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'hA5A5_0010};
        t6[3] = '{1'b1, 1'b0, 1'b1, 32'h14, 32'hA5A5_0010};
        t6[4] = '{1'b0, 1'b0, 1'b0, 32'h14, 32'hA5A5_0010};
        t6[5] = '{1'b0, 1'b1, 1'b0, 32'h14, 32'hA5A5_0014};
        t6[6] = '{1'b0, 1'b0, 1'b0, 32'h14, 32'hA5A5_0014};

        do_reset();
        check_zero("reset");

        // Read with busy tracked per cycle: issue, two wait cycles, then idle with RVALID
        d = cyc;
        expect_gnt(2'd0, 1'b0, 32'h100, 32'h0, d + 1);
        expect_rv(2'd0, 32'hDEAD_BEEF, d + 2 + LAT0);
        set_req(2'd0, 1'b1, 1'b0, 32'h100, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("busy_read", 64'(bus0.o_BUSY), 64'(k < 4));
        end
        drain();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Fairness: all three hold write requests from reset
        do_reset();
        auto_drop = 1'b0;
        base = gnt_seen;
        d = cyc;
        for (int k = 0; k < 6; k++) expect_gnt(2'(k % 3), 1'b1, 32'h300 + 32'(4 * (k % 3)), 32'hA0 + 32'(k % 3), d + 1 + 2 * k);
        for (int w = 0; w < 3; w++) set_req(2'(w), 1'b1, 1'b1, 32'h300 + 32'(4 * w), 32'hA0 + 32'(w));
        for (int i = 0; i < 30 && gnt_seen < base + 6; i++) step();
        chk("fair_count", 64'(gnt_seen - base), 64'd6);
        for (int w = 0; w < 3; w++) set_req(2'(w), 1'b0, 1'b1, 32'h0, 32'h0);
        auto_drop = 1'b1;
        drain();

        // Pointer at B after an A grant; A and C together go C then A
        do_reset();
        run_vec('{2'd0, 1'b1, 32'h400, 32'h11, 32'h0});
        d = cyc;
        expect_gnt(2'd2, 1'b1, 32'h408, 32'h33, d + 1);
        expect_gnt(2'd0, 1'b1, 32'h404, 32'h22, d + 3);
        set_req(2'd0, 1'b1, 1'b1, 32'h404, 32'h22);
        set_req(2'd2, 1'b1, 1'b1, 32'h408, 32'h33);
        drain();

        // Reset during WAIT of an A read
        do_reset();
        run_vec('{2'd0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF});
        d = cyc;
        expect_gnt(2'd0, 1'b0, 32'h104, 32'h0, d + 1);
        set_req(2'd0, 1'b1, 1'b0, 32'h104, 32'h0);
        step();
        step();
        chk("wait_busy", 64'(bus0.o_BUSY), 64'd1);
        rst = 1'b1;
        clear_inputs();
        gq.delete();
        rq.delete();
        for (int w = 0; w < 3; w++) exp_rd[w] = '0;
        @(negedge clk);
        check_zero("midreset");
        step();
        rst = 1'b0;
        repeat (LAT0 + 4) step();
        d = cyc;
        expect_gnt(2'd0, 1'b1, 32'h500, 32'h55, d + 1);
        expect_gnt(2'd1, 1'b1, 32'h504, 32'h66, d + 3);
        set_req(2'd0, 1'b1, 1'b1, 32'h500, 32'h55);
        set_req(2'd1, 1'b1, 1'b1, 32'h504, 32'h66);
        drain();

        // Back-to-back A reads on the latency-1 instance
        bus1.i_A_REQ = 1'b1;
        bus1.i_A_WR = 1'b0;
        bus1.i_A_ADDR = 32'h10;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            chk("b2b_ctrl", 64'({bus1.o_A_GNT, bus1.o_A_RVALID, bus1.o_RAM_RD}), 64'({t6[k].gnt, t6[k].rv, t6[k].rd}));
            chk("b2b_addr", 64'(bus1.o_RAM_ADDR), 64'(t6[k].addr));
            chk("b2b_data", 64'(bus1.o_A_DATA_RD), 64'(t6[k].data));
            if (k == 1) bus1.i_A_ADDR = 32'h14;
            if (k == 4) bus1.i_A_REQ = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
